rs_issue_scheduler: RTL and testbench

RS_ISSUE_SCHEDULER -- requirements
Module: rs_issue_scheduler

---
 rtl/core_pkg.sv | 37 +++
 rtl/rs_issue_select.sv | 43 ++++
 rtl/rs_issue_scheduler.sv | 173 +++++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: operand/tag widths, reservation-station operand and entry payloads,
// and the result-bus snoop used wherever an operand can pick up a broadcast value.
package core_pkg;

   localparam int unsigned REG_SIZE     = 64;
   localparam int unsigned GPR_COUNT    = 32;
   localparam int unsigned GPR_IDX_SIZE = $clog2(GPR_COUNT);

   typedef logic [GPR_IDX_SIZE-1:0] gpr_idx_t;

   typedef struct packed {
      logic                valid;
      gpr_idx_t            tag;
      logic [REG_SIZE-1:0] value;
   } rs_op;

   typedef struct packed {
      rs_op     op1;
      rs_op     op2;
      gpr_idx_t dst_tag;
   } rs_entry;

   // A pending operand whose tag matches a valid broadcast captures the broadcast value.
   function automatic rs_op cdb_snoop(input rs_op                op,
                                      input logic                cdb_valid,
                                      input gpr_idx_t            cdb_tag,
                                      input logic [REG_SIZE-1:0] cdb_value);
      rs_op res;
      res = op;
      if (cdb_valid && !op.valid && (op.tag == cdb_tag)) begin
         res.valid = 1'b1;
         res.value = cdb_value;
      end
      return res;
   endfunction

endpackage

// File: rtl/rs_issue_select.sv
// Issue selection: one-hot grant of a single ready reservation-station entry.
// Ports: i_ready (per-entry ready), i_age (age matrix, only with RS_AGE_ORDER_EN;
//        i_age[j][i]=1 means entry j is older than entry i), o_grant_c (one-hot grant, combinational).
// Macro RS_AGE_ORDER_EN: oldest ready entry wins; otherwise lowest-index ready entry wins.
module rs_issue_select #(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]        i_ready,
`ifdef RS_AGE_ORDER_EN
   input  logic [N-1:0][N-1:0] i_age,
`endif
   output logic [N-1:0]        o_grant_c
);

`ifdef RS_AGE_ORDER_EN
   // An entry is granted when no other ready entry is older than it.
   always_comb begin
      o_grant_c = '0;
      for (int i = 0; i < N; i++) begin
         logic blocked;
         blocked = 1'b0;
         for (int j = 0; j < N; j++) begin
            if (i_ready[j] && i_age[j][i]) blocked = 1'b1;
         end
         o_grant_c[i] = i_ready[i] && !blocked;
      end
   end
`else
   // Priority encoder towards index 0.
   logic found;
   always_comb begin
      o_grant_c = '0;
      found     = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i_ready[i] && !found) begin
            o_grant_c[i] = 1'b1;
            found        = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: holds RS_SIZE entries, snoops the CDB for pending
// operands and issues one ready entry per cycle through a one-deep output register.
// Ports: i_clk/i_reset_n (async active-low); i_alloc_* / o_alloc_ready allocation handshake;
//        i_cdb_* result broadcast; o_issue_* / i_issue_ready functional-unit handshake;
//        o_count occupied entries.
// Macro RS_AGE_ORDER_EN: oldest-ready selection via an RS_SIZE x RS_SIZE age matrix;
//        undefined: lowest-index ready selection, no age matrix.
module rs_issue_scheduler
   import core_pkg::rs_op, core_pkg::rs_entry, core_pkg::cdb_snoop;
#(
   parameter int unsigned RS_SIZE      = 2,
   parameter int unsigned REG_SIZE     = core_pkg::REG_SIZE,
   parameter int unsigned GPR_IDX_SIZE = core_pkg::GPR_IDX_SIZE
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  logic                         i_alloc_valid,
   output logic                         o_alloc_ready,
   input  rs_op                         i_alloc_op1,
   input  rs_op                         i_alloc_op2,
   input  logic [GPR_IDX_SIZE-1:0]      i_alloc_dst_tag,
   input  logic                         i_cdb_valid,
   input  logic [GPR_IDX_SIZE-1:0]      i_cdb_tag,
   input  logic [REG_SIZE-1:0]          i_cdb_value,
   output logic                         o_issue_valid,
   input  logic                         i_issue_ready,
   output logic [REG_SIZE-1:0]          o_issue_op1,
   output logic [REG_SIZE-1:0]          o_issue_op2,
   output logic [GPR_IDX_SIZE-1:0]      o_issue_dst_tag,
   output logic [$clog2(RS_SIZE+1)-1:0] o_count
);

   localparam int unsigned CNT_W = $clog2(RS_SIZE + 1);

   rs_entry                 entry_q [RS_SIZE];
   rs_entry                 entry_d [RS_SIZE];
   logic [RS_SIZE-1:0]      busy_q, busy_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    alloc_ready_q, alloc_ready_d;
   logic                    issue_valid_q, issue_valid_d;
   logic [REG_SIZE-1:0]     issue_op1_q, issue_op1_d, issue_op2_q, issue_op2_d;
   logic [GPR_IDX_SIZE-1:0] issue_dst_q, issue_dst_d;

   logic [RS_SIZE-1:0]      ready_c, grant_c, free_oh_c;
   logic                    alloc_fire_c, move_c, free_found;
   rs_entry                 sel_c;

   // Readiness comes from registered operand state only.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         ready_c[i] = busy_q[i] && entry_q[i].op1.valid && entry_q[i].op2.valid;
      end
   end

   // Lowest-index free slot; a slot freed this edge is still seen as busy.
   always_comb begin
      free_oh_c  = '0;
      free_found = 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (!busy_q[i] && !free_found) begin
            free_oh_c[i] = 1'b1;
            free_found   = 1'b1;
         end
      end
   end

`ifdef RS_AGE_ORDER_EN
   logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q, age_d;

   // New entry becomes younger than every other slot; stale bits of free slots never block.
   always_comb begin
      age_d = age_q;
      for (int k = 0; k < RS_SIZE; k++) begin
         if (alloc_fire_c && free_oh_c[k]) begin
            for (int i = 0; i < RS_SIZE; i++) begin
               age_d[k][i] = 1'b0;
               if (i != k) age_d[i][k] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) age_q <= '0;
      else            age_q <= age_d;
   end
`endif

   rs_issue_select #(.N(RS_SIZE)) u_select (
      .i_ready   (ready_c),
`ifdef RS_AGE_ORDER_EN
      .i_age     (age_q),
`endif
      .o_grant_c (grant_c)
   );

   // Payload of the granted entry (grant is one-hot or zero).
   always_comb begin
      sel_c = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (grant_c[i]) sel_c = entry_q[i];
      end
   end

   assign alloc_fire_c = i_alloc_valid && alloc_ready_q;
   assign move_c       = (!issue_valid_q || i_issue_ready) && (|ready_c);

   // Entry array, occupancy and output register next state.
   always_comb begin
      entry_d       = entry_q;
      busy_d        = busy_q;
      issue_valid_d = issue_valid_q;
      issue_op1_d   = issue_op1_q;
      issue_op2_d   = issue_op2_q;
      issue_dst_d   = issue_dst_q;

      for (int i = 0; i < RS_SIZE; i++) begin
         if (busy_q[i]) begin
            entry_d[i].op1 = cdb_snoop(entry_q[i].op1, i_cdb_valid, i_cdb_tag, i_cdb_value);
            entry_d[i].op2 = cdb_snoop(entry_q[i].op2, i_cdb_valid, i_cdb_tag, i_cdb_value);
         end
         if (move_c && grant_c[i]) busy_d[i] = 1'b0;
         if (alloc_fire_c && free_oh_c[i]) begin
            busy_d[i]          = 1'b1;
            entry_d[i].op1     = cdb_snoop(i_alloc_op1, i_cdb_valid, i_cdb_tag, i_cdb_value);
            entry_d[i].op2     = cdb_snoop(i_alloc_op2, i_cdb_valid, i_cdb_tag, i_cdb_value);
            entry_d[i].dst_tag = i_alloc_dst_tag;
         end
      end

      if (move_c) begin
         issue_valid_d = 1'b1;
         issue_op1_d   = sel_c.op1.value;
         issue_op2_d   = sel_c.op2.value;
         issue_dst_d   = sel_c.dst_tag;
      end else if (i_issue_ready) begin
         issue_valid_d = 1'b0;
      end

      count_d       = count_q + CNT_W'(alloc_fire_c) - CNT_W'(move_c);
      alloc_ready_d = (count_d < CNT_W'(RS_SIZE));
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < RS_SIZE; i++) entry_q[i] <= '0;
         busy_q        <= '0;
         count_q       <= '0;
         alloc_ready_q <= 1'b1;
         issue_valid_q <= 1'b0;
         issue_op1_q   <= '0;
         issue_op2_q   <= '0;
         issue_dst_q   <= '0;
      end else begin
         entry_q       <= entry_d;
         busy_q        <= busy_d;
         count_q       <= count_d;
         alloc_ready_q <= alloc_ready_d;
         issue_valid_q <= issue_valid_d;
         issue_op1_q   <= issue_op1_d;
         issue_op2_q   <= issue_op2_d;
         issue_dst_q   <= issue_dst_d;
      end
   end

   assign o_alloc_ready   = alloc_ready_q;
   assign o_issue_valid   = issue_valid_q;
   assign o_issue_op1     = issue_op1_q;
   assign o_issue_op2     = issue_op2_q;
   assign o_issue_dst_tag = issue_dst_q;
   assign o_count         = count_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench for rs_issue_scheduler: stimulus pushes expected issues, a negedge
// monitor pops and compares on every accepted issue.
module tb_rs_issue_scheduler;
   import core_pkg::*;

   localparam int unsigned RS = 2;

   logic           i_clk = 1'b0;
   logic           i_reset_n;
   logic           i_alloc_valid;
   logic           o_alloc_ready;
   rs_op           i_alloc_op1, i_alloc_op2;
   logic [4:0]     i_alloc_dst_tag;
   logic           i_cdb_valid;
   logic [4:0]     i_cdb_tag;
   logic [63:0]    i_cdb_value;
   logic           o_issue_valid;
   logic           i_issue_ready;
   logic [63:0]    o_issue_op1, o_issue_op2;
   logic [4:0]     o_issue_dst_tag;
   logic [1:0]     o_count;

   typedef struct packed {
      logic [63:0] op1;
      logic [63:0] op2;
      logic [4:0]  dst;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   rs_issue_scheduler #(.RS_SIZE(RS)) dut (
      .i_clk           (i_clk),
      .i_reset_n       (i_reset_n),
      .i_alloc_valid   (i_alloc_valid),
      .o_alloc_ready   (o_alloc_ready),
      .i_alloc_op1     (i_alloc_op1),
      .i_alloc_op2     (i_alloc_op2),
      .i_alloc_dst_tag (i_alloc_dst_tag),
      .i_cdb_valid     (i_cdb_valid),
      .i_cdb_tag       (i_cdb_tag),
      .i_cdb_value     (i_cdb_value),
      .o_issue_valid   (o_issue_valid),
      .i_issue_ready   (i_issue_ready),
      .o_issue_op1     (o_issue_op1),
      .o_issue_op2     (o_issue_op2),
      .o_issue_dst_tag (o_issue_dst_tag),
      .o_count         (o_count)
   );

   always #5 i_clk = ~i_clk;

   // Monitor: every accepted issue must match the head of the scoreboard.
   always @(negedge i_clk) begin
      if (i_reset_n && o_issue_valid && i_issue_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_issue: got op1=%0h op2=%0h dst=%0d, required no issue",
                     o_issue_op1, o_issue_op2, o_issue_dst_tag);
         end else begin
            mon_e = exp_q.pop_front();
            if ({o_issue_op1, o_issue_op2, o_issue_dst_tag} !== mon_e) begin
               n_bad++;
               $display("FAIL issue_payload: got op1=%0h op2=%0h dst=%0d, required op1=%0h op2=%0h dst=%0d",
                        o_issue_op1, o_issue_op2, o_issue_dst_tag, mon_e.op1, mon_e.op2, mon_e.dst);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic rs_op mk(input logic v, input logic [4:0] t, input logic [63:0] val);
      rs_op o;
      o.valid = v;
      o.tag   = t;
      o.value = val;
      return o;
   endfunction

   function automatic exp_t ex(input logic [63:0] a, input logic [63:0] b, input logic [4:0] d);
      exp_t e;
      e.op1 = a;
      e.op2 = b;
      e.dst = d;
      return e;
   endfunction

   // One clock cycle of stimulus; returns #1 after the rising edge.
   task automatic cyc(input logic av, input rs_op o1, input rs_op o2, input logic [4:0] dst,
                      input logic cv, input logic [4:0] ct, input logic [63:0] cval);
      i_alloc_valid   = av;
      i_alloc_op1     = o1;
      i_alloc_op2     = o2;
      i_alloc_dst_tag = dst;
      i_cdb_valid     = cv;
      i_cdb_tag       = ct;
      i_cdb_value     = cval;
      @(posedge i_clk);
      #1;
      i_alloc_valid = 1'b0;
      i_cdb_valid   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, '0, '0, '0, 1'b0, '0, '0);
   endtask

   // Bounded wait for the scoreboard to empty.
   task automatic drain(input string name);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
      check(name, 64'(exp_q.size()), 64'd0);
      idle(2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      i_reset_n = 1'b0;
      i_alloc_valid = 1'b0; i_alloc_op1 = '0; i_alloc_op2 = '0; i_alloc_dst_tag = '0;
      i_cdb_valid = 1'b0; i_cdb_tag = '0; i_cdb_value = '0;
      i_issue_ready = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_valid", 64'(o_issue_valid), 64'd0);
      check("rst_count", 64'(o_count), 64'd0);
      check("rst_alloc_ready", 64'(o_alloc_ready), 64'd1);
      check("rst_payload", {o_issue_op1 | o_issue_op2}, 64'd0);
      i_reset_n = 1'b1;
      idle(1);

      // Both operands valid: issue visible after the second edge.
      exp_q.push_back(ex(64'd10, 64'd20, 5'd7));
      cyc(1'b1, mk(1'b1, 5'd3, 64'd10), mk(1'b1, 5'd4, 64'd20), 5'd7, 1'b0, '0, '0);
      check("t1_count_after_alloc", 64'(o_count), 64'd1);
      check("t1_valid_after_E", 64'(o_issue_valid), 64'd0);
      idle(1);
      check("t1_valid_after_E1", 64'(o_issue_valid), 64'd1);
      check("t1_count_after_move", 64'(o_count), 64'd0);
      drain("t1_drain");

      // Pending op1 on tag 5; tag 6 broadcast must not wake it.
      cyc(1'b1, mk(1'b0, 5'd5, 64'd0), mk(1'b1, 5'd1, 64'd2), 5'd3, 1'b0, '0, '0);
      cyc(1'b0, '0, '0, '0, 1'b1, 5'd6, 64'h66);
      idle(1);
      check("t2_no_wake_valid", 64'(o_issue_valid), 64'd0);
      check("t2_no_wake_count", 64'(o_count), 64'd1);
      exp_q.push_back(ex(64'h55, 64'd2, 5'd3));
      cyc(1'b0, '0, '0, '0, 1'b1, 5'd5, 64'h55);
      check("t2_valid_after_cdb", 64'(o_issue_valid), 64'd0);
      idle(1);
      check("t2_valid_next", 64'(o_issue_valid), 64'd1);
      drain("t2_drain");

      // Same-cycle capture; op2 already valid with the same tag keeps its value.
      exp_q.push_back(ex(64'd3, 64'd7, 5'd4));
      cyc(1'b1, mk(1'b0, 5'd9, 64'd0), mk(1'b1, 5'd9, 64'd7), 5'd4, 1'b1, 5'd9, 64'd3);
      idle(1);
      check("t3_valid", 64'(o_issue_valid), 64'd1);
      drain("t3_drain");

      // Fill while the FU stalls; third alloc ignored, output stable.
      i_issue_ready = 1'b0;
      cyc(1'b1, mk(1'b1, 5'd0, 64'hA), mk(1'b1, 5'd0, 64'hB), 5'd1, 1'b0, '0, '0);
      cyc(1'b1, mk(1'b1, 5'd0, 64'hC), mk(1'b1, 5'd0, 64'hD), 5'd2, 1'b0, '0, '0);
      check("t4_count_1", 64'(o_count), 64'd1);
      cyc(1'b1, mk(1'b1, 5'd0, 64'hE), mk(1'b1, 5'd0, 64'hF), 5'd3, 1'b0, '0, '0);
      check("t4_count_full", 64'(o_count), 64'd2);
      check("t4_alloc_ready_full", 64'(o_alloc_ready), 64'd0);
      cyc(1'b1, mk(1'b1, 5'd0, 64'h1), mk(1'b1, 5'd0, 64'h2), 5'd4, 1'b0, '0, '0);
      check("t4_count_ignored", 64'(o_count), 64'd2);
      idle(2);
      check("t4_hold_valid", 64'(o_issue_valid), 64'd1);
      check("t4_hold_op1", o_issue_op1, 64'hA);
      check("t4_hold_dst", 64'(o_issue_dst_tag), 64'd1);
      exp_q.push_back(ex(64'hA, 64'hB, 5'd1));
`ifdef RS_AGE_ORDER_EN
      exp_q.push_back(ex(64'hC, 64'hD, 5'd2));
      exp_q.push_back(ex(64'hE, 64'hF, 5'd3));
`else
      exp_q.push_back(ex(64'hE, 64'hF, 5'd3));
      exp_q.push_back(ex(64'hC, 64'hD, 5'd2));
`endif
      i_issue_ready = 1'b1;
      drain("t4_drain");
      check("t4_count_empty", 64'(o_count), 64'd0);

      // A lands in entry1 before B lands in entry0; both become ready together.
      exp_q.push_back(ex(64'h11, 64'h12, 5'd1));
`ifdef RS_AGE_ORDER_EN
      exp_q.push_back(ex(64'hA1, 64'hA2, 5'd10));
      exp_q.push_back(ex(64'hB1, 64'hB2, 5'd11));
`else
      exp_q.push_back(ex(64'hB1, 64'hB2, 5'd11));
      exp_q.push_back(ex(64'hA1, 64'hA2, 5'd10));
`endif
      cyc(1'b1, mk(1'b1, 5'd0, 64'h11), mk(1'b1, 5'd0, 64'h12), 5'd1, 1'b0, '0, '0);
      cyc(1'b1, mk(1'b0, 5'd13, 64'd0), mk(1'b1, 5'd0, 64'hA2), 5'd10, 1'b0, '0, '0);
      cyc(1'b1, mk(1'b1, 5'd0, 64'hB1), mk(1'b1, 5'd0, 64'hB2), 5'd11, 1'b1, 5'd13, 64'hA1);
      drain("t5_drain");

      // Reset mid-cycle with a held output and a pending entry.
      i_issue_ready = 1'b0;
      cyc(1'b1, mk(1'b1, 5'd0, 64'h77), mk(1'b1, 5'd0, 64'h88), 5'd5, 1'b0, '0, '0);
      cyc(1'b1, mk(1'b0, 5'd20, 64'd0), mk(1'b1, 5'd0, 64'd1), 5'd6, 1'b0, '0, '0);
      check("t6_pre_valid", 64'(o_issue_valid), 64'd1);
      check("t6_pre_count", 64'(o_count), 64'd1);
      @(negedge i_clk);
      #1;
      i_reset_n = 1'b0;
      #1;
      check("t6_rst_valid", 64'(o_issue_valid), 64'd0);
      check("t6_rst_count", 64'(o_count), 64'd0);
      check("t6_rst_alloc_ready", 64'(o_alloc_ready), 64'd1);
      check("t6_rst_payload", {o_issue_op1 | o_issue_op2}, 64'd0);
      check("t6_rst_dst", 64'(o_issue_dst_tag), 64'd0);
      @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
      i_issue_ready = 1'b1;
      cyc(1'b0, '0, '0, '0, 1'b1, 5'd20, 64'h99);
      idle(4);
      check("t6_post_valid", 64'(o_issue_valid), 64'd0);
      check("t6_post_count", 64'(o_count), 64'd0);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
